// File: rtl/uram_port_arb.sv
// uram_port_arb
// Shares one port of the byte-write URAM between two masters. Round-robin
// arbitration with a bounded lock, combinational same-cycle grant, and a
// fixed-latency read-tag pipeline that routes each read response back to
// the master that issued it.

module uram_port_arb #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 16,
    parameter int RD_LAT     = 1,
    parameter int MAX_LOCK   = 16
) (
    input  logic                    clk,
    input  logic                    rst_b,

    input  logic                    m0_req,
    input  logic                    m0_wr,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
    input  logic                    m0_lock,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,

    input  logic                    m1_req,
    input  logic                    m1_wr,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    input  logic                    m1_lock,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,

    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_din,
    output logic [DATA_WIDTH/8-1:0] ram_we,
    input  logic [DATA_WIDTH-1:0]   ram_dout,

    output logic                    rr_last
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = 8;

    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(MAX_LOCK);

    // Master identifiers, used for rr_last, the lock owner and read tags.
    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

    // Arbitration state.
    logic             rr_q;
    logic             lock_act_q;
    logic             lock_own_q;
    logic [CNT_W-1:0] lock_cnt_q;

    // Read-tag pipeline: stage RD_LAT-1 lines up with valid ram_dout.
    logic [RD_LAT-1:0] tag_vld_q;
    logic [RD_LAT-1:0] tag_id_q;

    // Combinational arbitration results.
    logic lock_hold;
    logic lock_expired;
    logic gnt0;
    logic gnt1;
    logic gnt_any;
    logic gnt_id;
    logic sel_wr;
    logic sel_lock;

    // A lock is honoured only while its owner still requests and the
    // consecutive-grant budget has not been used up.
    assign lock_expired = lock_act_q && (lock_cnt_q >= LOCK_LIMIT);
    assign lock_hold    = lock_act_q && (lock_cnt_q < LOCK_LIMIT) &&
                          ((lock_own_q == ID_M1) ? m1_req : m0_req);

    // Grant selection: lock owner, then lone requester, then round robin.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_b) begin
            if (lock_hold) begin
                gnt0 = (lock_own_q == ID_M0);
                gnt1 = (lock_own_q == ID_M1);
            end else if (m0_req && !m1_req) begin
                gnt0 = 1'b1;
            end else if (m1_req && !m0_req) begin
                gnt1 = 1'b1;
            end else if (m0_req && m1_req) begin
                // The master that did not win last time takes the contest.
                gnt0 = (rr_q == ID_M1);
                gnt1 = (rr_q == ID_M0);
            end
        end
    end

    assign gnt_any  = gnt0 | gnt1;
    assign gnt_id   = gnt1 ? ID_M1 : ID_M0;
    assign sel_wr   = gnt1 ? m1_wr   : m0_wr;
    assign sel_lock = gnt1 ? m1_lock : m0_lock;

    assign m0_gnt  = gnt0;
    assign m1_gnt  = gnt1;
    assign rr_last = rr_q;

    // RAM port mux: the granted master drives the port, idle port is all zero.
    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = '0;
        if (gnt0) begin
            ram_addr = m0_addr;
            ram_din  = m0_wdata;
            ram_we   = m0_wr ? m0_wstrb : {STRB_W{1'b0}};
        end else if (gnt1) begin
            ram_addr = m1_addr;
            ram_din  = m1_wdata;
            ram_we   = m1_wr ? m1_wstrb : {STRB_W{1'b0}};
        end
    end

    // Round-robin pointer and lock bookkeeping, updated on every cycle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rr_q       <= ID_M1;
            lock_act_q <= 1'b0;
            lock_own_q <= ID_M0;
            lock_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its inputs.
            if (gnt_any) begin
                rr_q <= gnt_id;
            end
            if (gnt_any && sel_lock && !lock_expired) begin
                lock_act_q <= 1'b1;
                lock_own_q <= gnt_id;
                if (lock_act_q && (lock_own_q == gnt_id)) begin
                    lock_cnt_q <= lock_cnt_q + 1'b1;
                end else begin
                    lock_cnt_q <= CNT_W'(1);
                end
            end else begin
                // Lock dropped, owner idle, other master won, or budget used.
                lock_act_q <= 1'b0;
                lock_cnt_q <= '0;
            end
        end
    end

    // Read-tag shift register: one {valid, id} entry per cycle of RAM latency.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            // NOTE: the tag pipeline is reset (unlike RAM contents) so reads
            // in flight at reset never raise rvalid afterwards.
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            tag_vld_q[0] <= gnt_any & ~sel_wr;
            tag_id_q[0]  <= gnt_id;
            for (int s = RD_LAT - 1; s > 0; s--) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
        end
    end

    assign m0_rvalid = tag_vld_q[RD_LAT-1] & (tag_id_q[RD_LAT-1] == ID_M0);
    assign m1_rvalid = tag_vld_q[RD_LAT-1] & (tag_id_q[RD_LAT-1] == ID_M1);
    assign m0_rdata  = ram_dout;
    assign m1_rdata  = ram_dout;

endmodule
